// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT defines: default sizes, read-engine states and the bit-reverse helper.
package fft_bitrev_reorder_pkg;

  localparam int unsigned FFT_N          = 1024;
  localparam int unsigned FFT_N_LOG2     = 10;
  localparam int unsigned FFT_DATA_WIDTH = 25;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [FFT_N_LOG2-1:0] bitrev(input logic [FFT_N_LOG2-1:0] v,
                                                   input int unsigned w);
    logic [FFT_N_LOG2-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FFT_N_LOG2; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port RAM holding both ping-pong banks; address = {bank, index}.
module fft_bitrev_ram #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned WIDTH      = 50
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Synchronous one-cycle read port.
  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders a bit-reversed FFT output stream into natural bin order via ping-pong banks.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned N          = FFT_N,
  parameter int unsigned N_LOG2     = FFT_N_LOG2,
  parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         sync_i,
  input  logic [N_LOG2-1:0]            ctr_i,
  input  logic signed [DATA_WIDTH-1:0] data_re_i,
  input  logic signed [DATA_WIDTH-1:0] data_im_i,
  output logic                         sync_o,
  output logic [N_LOG2-1:0]            data_ctr_o,
  output logic signed [DATA_WIDTH-1:0] data_re_o,
  output logic signed [DATA_WIDTH-1:0] data_im_o,
  output logic                         seq_err_o
);

  localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

  // Write side
  logic [N_LOG2-1:0]     wcnt;
  logic                  wbank;
  logic [FFT_N_LOG2-1:0] exp_full;
  logic [N_LOG2-1:0]     exp_idx;
  logic                  frame_done;
  logic                  collide;

  // Read engine
  rd_state_e         state_q, state_d;
  logic [N_LOG2-1:0] raddr_q, raddr_d;
  logic              rbank_q, rbank_d;
  logic              rd_en;

  // Output pipeline
  logic                      rd_vld_q;
  logic [N_LOG2-1:0]         rd_idx_q;
  logic [2*DATA_WIDTH-1:0]   rdata;

  assign exp_full   = bitrev(FFT_N_LOG2'(wcnt), N_LOG2);
  assign exp_idx    = exp_full[N_LOG2-1:0];
  assign frame_done = sync_i && (wcnt == LAST_IDX);
  assign collide    = frame_done && (state_q == RD_RUN) && (raddr_q != LAST_IDX);
  assign rd_en      = (state_q == RD_RUN);

  // Write counter, bank toggle and sticky sequence-error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      seq_err_o <= 1'b0;
    end else begin
      if (sync_i) begin
        if (frame_done) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end else begin
        wcnt <= '0;
      end
      if ((sync_i && (ctr_i != exp_idx)) || collide) seq_err_o <= 1'b1;
    end
  end

  // Read engine state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      raddr_q <= '0;
      rbank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rbank_q <= rbank_d;
    end
  end

  // Read engine next state: any frame completion (re)starts at 0 on the bank just filled.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rbank_d = rbank_q;
    if (frame_done) begin
      state_d = RD_RUN;
      raddr_d = '0;
      rbank_d = wbank;
    end else if (state_q == RD_RUN) begin
      if (raddr_q == LAST_IDX) begin
        state_d = RD_IDLE;
      end else begin
        raddr_d = raddr_q + 1'b1;
      end
    end
  end

  fft_bitrev_ram #(
    .ADDR_WIDTH(N_LOG2 + 1),
    .WIDTH     (2 * DATA_WIDTH)
  ) u_ram (
    .clk_i  (clk_i),
    .wr_en  (sync_i),
    .wr_addr({wbank, ctr_i}),
    .wr_data({data_re_i, data_im_i}),
    .rd_en  (rd_en),
    .rd_addr({rbank_q, raddr_q}),
    .rd_data(rdata)
  );

  // Align the read index with the RAM's one-cycle read latency.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      rd_idx_q <= raddr_q;
    end
  end

  // Output register; data and index hold their last value while sync_o is low.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sync_o     <= 1'b0;
      data_ctr_o <= '0;
      data_re_o  <= '0;
      data_im_o  <= '0;
    end else begin
      sync_o <= rd_vld_q;
      if (rd_vld_q) begin
        data_ctr_o <= rd_idx_q;
        data_re_o  <= signed'(rdata[2*DATA_WIDTH-1:DATA_WIDTH]);
        data_im_o  <= signed'(rdata[DATA_WIDTH-1:0]);
      end
    end
  end

endmodule
